// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Constants and helpers shared by the FFT stage blocks.
//   COS_Q14     : 64-entry cosine table, Q2.14, entry i = round(cos(2*pi*i/64)*2^14).
//                 The -sin term is read from the same table a quarter turn later.
//   TW_ONE      : unity in Q2.14.
//   MAX_LOG2N   : largest supported FFT order (table covers N = 64).
//   tw_from_q14 : rescales a Q2.14 table entry to a Q2.(tw-2) twiddle.
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int MAX_LOG2N = 6;
    localparam int TBL_SIZE  = 64;
    localparam int TBL_FRAC  = 14;
    localparam int TW_ONE    = 1 << TBL_FRAC;

    localparam logic signed [15:0] COS_Q14 [TBL_SIZE] = '{
         16384,  16305,  16069,  15679,  15137,  14449,  13623,  12665,
         11585,  10394,   9102,   7723,   6270,   4756,   3196,   1606,
             0,  -1606,  -3196,  -4756,  -6270,  -7723,  -9102, -10394,
        -11585, -12665, -13623, -14449, -15137, -15679, -16069, -16305,
        -16384, -16305, -16069, -15679, -15137, -14449, -13623, -12665,
        -11585, -10394,  -9102,  -7723,  -6270,  -4756,  -3196,  -1606,
             0,   1606,   3196,   4756,   6270,   7723,   9102,  10394,
         11585,  12665,  13623,  14449,  15137,  15679,  16069,  16305
    };

    // Wider twiddles are an exact left shift; narrower ones round half-up
    // so small TW still lands on the nearest representable value.
    function automatic logic signed [31:0] tw_from_q14(input logic signed [15:0] v,
                                                       input int tw);
        logic signed [31:0] x;
        x = 32'(v);
        if (tw - 2 >= TBL_FRAC)
            return x <<< (tw - 2 - TBL_FRAC);
        else
            return (x + (32'sd1 <<< (TBL_FRAC - (tw - 2) - 1))) >>> (TBL_FRAC - (tw - 2));
    endfunction

endpackage

// File: rtl/bfu_cmul.sv
// ---------------------------------------------------------------------------
// bfu_cmul
// Complex multiply p = b * w. The four partial products are registered (the
// second pipeline stage); the sum/difference and round half-up to Q0 follow
// combinationally so the owner can fold them into its third-stage register.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   en             pipeline advance; products hold when low
//   b_re, b_im     DW-bit signed operand
//   w_re, w_im     TW-bit signed twiddle, Q2.(TW-2)
//   p_re, p_im     DW+2-bit signed rounded product
// ---------------------------------------------------------------------------
module bfu_cmul #(
    parameter int DW = 32,
    parameter int TW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic signed [TW-1:0] w_re,
    input  logic signed [TW-1:0] w_im,
    output logic signed [DW+1:0] p_re,
    output logic signed [DW+1:0] p_im
);

    localparam int PW = DW + TW;
    localparam logic signed [PW:0] RND = (PW + 1)'(2 ** (TW - 3));

    logic signed [PW-1:0] rr, ii, ri, ir;
    logic signed [PW:0]   sum_re, sum_im;
    logic signed [PW:0]   rnd_re, rnd_im;
    logic                 unused_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= '0;
            ii <= '0;
            ri <= '0;
            ir <= '0;
        end else if (en) begin
            rr <= b_re * w_re;
            ii <= b_im * w_im;
            ri <= b_re * w_im;
            ir <= b_im * w_re;
        end
    end

    // After the shift the value fits DW+2 bits; the bits above are sign copies.
    always_comb begin
        sum_re = (PW + 1)'(rr) - (PW + 1)'(ii);
        sum_im = (PW + 1)'(ri) + (PW + 1)'(ir);
        rnd_re = (sum_re + RND) >>> (TW - 2);
        rnd_im = (sum_im + RND) >>> (TW - 2);
    end

    assign p_re        = rnd_re[DW+1:0];
    assign p_im        = rnd_im[DW+1:0];
    assign unused_bits = ^{rnd_re[PW:DW+2], rnd_im[PW:DW+2]};

endmodule

// File: rtl/bfu_pipe.sv
// ---------------------------------------------------------------------------
// bfu_pipe
// Pipelined radix-2 DIT butterfly: x0 = a + W*b, x1 = a - W*b, W = W_N^k.
// Three register stages (operands+twiddle, products, results), valid/ready
// flow control with a single global enable, latency 3, one beat per cycle.
// Build option: define BFU_SAT_EN to clamp out-of-range results and raise
// the sticky ovf flag; without it results wrap and ovf is tied low.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    input handshake
//   a_re, a_im, b_re, b_im DW-bit signed operands
//   k                      twiddle index (LOG2N-1 bits)
//   out_valid / out_ready  output handshake
//   x0_re, x0_im           a + W*b
//   x1_re, x1_im           a - W*b
//   ovf                    sticky overflow flag, cleared only by rst
// ---------------------------------------------------------------------------
module bfu_pipe
    import fft_pkg::*;
#(
    parameter int DW    = 32,
    parameter int TW    = 16,
    parameter int LOG2N = 3,
    parameter int SCALE = 0,
    localparam int KW   = (LOG2N > 1) ? LOG2N - 1 : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic        [KW-1:0] k,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] x0_re,
    output logic signed [DW-1:0] x0_im,
    output logic signed [DW-1:0] x1_re,
    output logic signed [DW-1:0] x1_im,
    output logic                 ovf
);

    logic                 en;
    logic [5:0]           idx_re, idx_im;
    logic signed [31:0]   wr_full, wi_full;

    logic                 s1_valid;
    logic signed [DW-1:0] s1_a_re, s1_a_im, s1_b_re, s1_b_im;
    logic signed [TW-1:0] s1_wr, s1_wi;

    logic                 s2_valid;
    logic signed [DW-1:0] s2_a_re, s2_a_im;

    logic signed [DW+1:0] p_re, p_im;
    logic signed [DW+1:0] wide   [4];
    logic        [DW-1:0] narrow [4];
    logic                 unused_bits;

    // One enable for every stage: the whole pipe moves unless a valid
    // result is sitting at the output and downstream refuses it.
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // Table index k*(64/N); -sin(x) equals cos(x + pi/2), a quarter turn on.
    always_comb begin
        idx_re  = 6'(k) << (MAX_LOG2N - LOG2N);
        idx_im  = idx_re + 6'd16;
        wr_full = tw_from_q14(COS_Q14[idx_re], TW);
        wi_full = tw_from_q14(COS_Q14[idx_im], TW);
    end

    // Stage 1: capture operands and twiddle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a_re  <= '0;
            s1_a_im  <= '0;
            s1_b_re  <= '0;
            s1_b_im  <= '0;
            s1_wr    <= '0;
            s1_wi    <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_a_re  <= a_re;
            s1_a_im  <= a_im;
            s1_b_re  <= b_re;
            s1_b_im  <= b_im;
            s1_wr    <= wr_full[TW-1:0];
            s1_wi    <= wi_full[TW-1:0];
        end
    end

    // Stage 2: products live in the multiplier; A and valid ride alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_a_re  <= '0;
            s2_a_im  <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_a_re  <= s1_a_re;
            s2_a_im  <= s1_a_im;
        end
    end

    bfu_cmul #(
        .DW (DW),
        .TW (TW)
    ) u_cmul (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .b_re (s1_b_re),
        .b_im (s1_b_im),
        .w_re (s1_wr),
        .w_im (s1_wi),
        .p_re (p_re),
        .p_im (p_im)
    );

    // Add/sub at DW+2 bits (cannot overflow there), optional halving with floor.
    always_comb begin
        wide[0] = (DW + 2)'(s2_a_re) + p_re;
        wide[1] = (DW + 2)'(s2_a_im) + p_im;
        wide[2] = (DW + 2)'(s2_a_re) - p_re;
        wide[3] = (DW + 2)'(s2_a_im) - p_im;
        if (SCALE != 0) begin
            for (int i = 0; i < 4; i++) begin
                wide[i] = wide[i] >>> 1;
            end
        end
    end

`ifdef BFU_SAT_EN
    logic [3:0] clip;

    // A value fits DW bits exactly when its top three bits agree.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            narrow[i] = wide[i][DW-1:0];
            clip[i]   = 1'b0;
            if (wide[i][DW+1:DW-1] != 3'b000 && wide[i][DW+1:DW-1] != 3'b111) begin
                clip[i]   = 1'b1;
                narrow[i] = wide[i][DW+1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ovf <= 1'b0;
        else if (en && s2_valid && (|clip))
            ovf <= 1'b1;
    end
`else
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            narrow[i] = wide[i][DW-1:0];
        end
    end

    assign ovf = 1'b0;
`endif

    assign unused_bits = ^{wide[0][DW+1:DW], wide[1][DW+1:DW],
                           wide[2][DW+1:DW], wide[3][DW+1:DW],
                           wr_full[31:TW], wi_full[31:TW]};

    // Stage 3: results load only with a valid beat so they hold between beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            x0_re     <= '0;
            x0_im     <= '0;
            x1_re     <= '0;
            x1_im     <= '0;
        end else if (en) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                x0_re <= narrow[0];
                x0_im <= narrow[1];
                x1_re <= narrow[2];
                x1_im <= narrow[3];
            end
        end
    end

endmodule

// File: tb/tb_bfu_pipe.sv
// ---------------------------------------------------------------------------
// tb_bfu_pipe
// Drives a full-scale and a halving (SCALE=1) butterfly from the same
// handshake and compares every output beat against a queue of results
// computed from the butterfly definition with 64-bit integer arithmetic
// and a floating-point twiddle.
// ---------------------------------------------------------------------------
module tb_bfu_pipe;

    localparam int DW    = 32;
    localparam int TW    = 16;
    localparam int LOG2N = 3;
    localparam int N     = 1 << LOG2N;
    localparam int KW    = LOG2N - 1;

    typedef struct {
        longint x0r, x0i, x1r, x1i;
        bit     clip;
        longint s0r, s0i, s1r, s1i;
        bit     clip_s;
    } res_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready, in_ready_s;
    logic signed [DW-1:0] a_re, a_im, b_re, b_im;
    logic        [KW-1:0] k;
    logic                 out_valid, out_valid_s;
    logic                 out_ready;
    logic signed [DW-1:0] x0_re, x0_im, x1_re, x1_im;
    logic signed [DW-1:0] x0_re_s, x0_im_s, x1_re_s, x1_im_s;
    logic                 ovf, ovf_s;

    int   nCompared   = 0;
    int   nMismatched = 0;
    bit   randReady   = 0;
    bit   ovfExp      = 0;
    bit   ovfExpS     = 0;
    res_t sb[$];
    res_t e;

    always #5 clk = ~clk;

    bfu_pipe #(.DW(DW), .TW(TW), .LOG2N(LOG2N), .SCALE(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .k(k),
        .out_valid(out_valid), .out_ready(out_ready),
        .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im), .ovf(ovf)
    );

    bfu_pipe #(.DW(DW), .TW(TW), .LOG2N(LOG2N), .SCALE(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .k(k),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .x0_re(x0_re_s), .x0_im(x0_im_s), .x1_re(x1_re_s), .x1_im(x1_im_s), .ovf(ovf_s)
    );

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic longint twid(input int kk, input bit imag);
        real ang, r;
        ang = 2.0 * 3.14159265358979 * kk / N;
        r   = (imag ? -$sin(ang) : $cos(ang)) * real'(2 ** (TW - 2));
        return (r >= 0.0) ? longint'($rtoi(r + 0.5)) : -longint'($rtoi(-r + 0.5));
    endfunction

    function automatic longint fitDw(input longint v, output bit c);
        c = 1'b0;
`ifdef BFU_SAT_EN
        if (v > (longint'(1) <<< (DW - 1)) - 1) begin
            c = 1'b1;
            return (longint'(1) <<< (DW - 1)) - 1;
        end
        if (v < -(longint'(1) <<< (DW - 1))) begin
            c = 1'b1;
            return -(longint'(1) <<< (DW - 1));
        end
        return v;
`else
        return longint'(int'(v));
`endif
    endfunction

    function automatic res_t bfModel(input longint ar, ai, br, bi, input int kk);
        res_t   r;
        longint wr, wi, pr, pi;
        longint s [4];
        bit     c [8];
        wr = twid(kk, 1'b0);
        wi = twid(kk, 1'b1);
        pr = (br * wr - bi * wi + 2 ** (TW - 3)) >>> (TW - 2);
        pi = (br * wi + bi * wr + 2 ** (TW - 3)) >>> (TW - 2);
        s[0] = ar + pr;
        s[1] = ai + pi;
        s[2] = ar - pr;
        s[3] = ai - pi;
        r.x0r = fitDw(s[0], c[0]);
        r.x0i = fitDw(s[1], c[1]);
        r.x1r = fitDw(s[2], c[2]);
        r.x1i = fitDw(s[3], c[3]);
        r.s0r = fitDw(s[0] >>> 1, c[4]);
        r.s0i = fitDw(s[1] >>> 1, c[5]);
        r.s1r = fitDw(s[2] >>> 1, c[6]);
        r.s1i = fitDw(s[3] >>> 1, c[7]);
        r.clip   = c[0] | c[1] | c[2] | c[3];
        r.clip_s = c[4] | c[5] | c[6] | c[7];
        return r;
    endfunction

    // Scoreboard: handshakes are judged just before the edge that acts on them.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            ovfExp  = 1'b0;
            ovfExpS = 1'b0;
        end else begin
            checkOutput("in_ready", in_ready, !out_valid || out_ready);
            checkOutput("s_valid_match", out_valid_s, out_valid);
            if (out_valid && out_ready) begin
                checkOutput("beat_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e       = sb.pop_front();
                    ovfExp  = ovfExp | e.clip;
                    ovfExpS = ovfExpS | e.clip_s;
                    checkOutput("x0_re", x0_re, e.x0r);
                    checkOutput("x0_im", x0_im, e.x0i);
                    checkOutput("x1_re", x1_re, e.x1r);
                    checkOutput("x1_im", x1_im, e.x1i);
                    checkOutput("x0_re_s", x0_re_s, e.s0r);
                    checkOutput("x0_im_s", x0_im_s, e.s0i);
                    checkOutput("x1_re_s", x1_re_s, e.s1r);
                    checkOutput("x1_im_s", x1_im_s, e.s1i);
                    checkOutput("ovf", ovf, ovfExp);
                    checkOutput("ovf_s", ovf_s, ovfExpS);
                end
            end
            if (in_valid && in_ready)
                sb.push_back(bfModel(a_re, a_im, b_re, b_im, int'(k)));
        end
    end

    // Random downstream readiness while randReady is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (randReady)
                out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic applyStimulus(input logic signed [DW-1:0] ar, ai, br, bi,
                                 input int kk);
        bit acc;
        int guard;
        in_valid = 1'b1;
        a_re     = ar;
        a_im     = ai;
        b_re     = br;
        b_im     = bi;
        k        = KW'(kk);
        acc      = 1'b0;
        guard    = 0;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc)
            checkOutput("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drainQueue();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        checkOutput("drain_empty", sb.size(), 0);
    endtask

    function automatic logic signed [DW-1:0] randVal();
        case ($urandom_range(0, 2))
            0:       return $urandom;
            1:       return DW'($signed($urandom_range(0, 2000)) - 1000);
            default: return ($urandom_range(0, 1) != 0) ? DW'(32'h7fff_ff00 + $urandom_range(0, 255))
                                                        : DW'(32'h8000_0000 + $urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0; k = '0;
        tick(3);
        rst = 1'b0;

        @(negedge clk);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_ovf", ovf, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_x0_re", x0_re, 0);
        checkOutput("rst_x1_im", x1_im, 0);
        tick(1);

        // W = -j then W = 1, back to back: exactly 3 cycles latency, 2 consecutive beats.
        applyStimulus(-300, 0, 100, 0, 2);
        applyStimulus(200, 0, 300, 0, 0);
        @(negedge clk);
        checkOutput("lat_early", out_valid, 0);
        @(negedge clk);
        checkOutput("lat_beat1", out_valid, 1);
        checkOutput("t1_x0_re", x0_re, -300);
        checkOutput("t1_x0_im", x0_im, -100);
        checkOutput("t1_x1_im", x1_im, 100);
        @(negedge clk);
        checkOutput("lat_beat2", out_valid, 1);
        checkOutput("t2_x0_re", x0_re, 500);
        checkOutput("t2_x1_re", x1_re, -100);
        @(negedge clk);
        checkOutput("lat_after", out_valid, 0);
        tick(1);

        // W = (1 - j)/sqrt2 and the halving build.
        applyStimulus(0, 0, 1000, 0, 1);
        repeat (3) @(negedge clk);
        checkOutput("t3_x0_re", x0_re, 707);
        checkOutput("t3_x0_im", x0_im, -707);
        checkOutput("t3_x1_re", x1_re, -707);
        tick(1);
        applyStimulus(201, 0, 100, 0, 0);
        repeat (3) @(negedge clk);
        checkOutput("t4_x0_re_s", x0_re_s, 150);
        checkOutput("t4_x1_re_s", x1_re_s, 50);
        tick(1);

        // Five-cycle backpressure in the middle of a four-beat burst.
        fork
            begin
                for (int i = 0; i < 4; i++)
                    applyStimulus(randVal(), randVal(), randVal(), randVal(), i);
            end
            begin
                tick(3);
                out_ready = 1'b0;
                tick(2);
                @(negedge clk);
                checkOutput("stall_out_valid", out_valid, 1);
                checkOutput("stall_in_ready", in_ready, 0);
                tick(3);
                out_ready = 1'b1;
            end
        join
        drainQueue();

        // Random traffic with random backpressure and idle gaps.
        randReady = 1'b1;
        for (int i = 0; i < 150; i++) begin
            applyStimulus(randVal(), randVal(), randVal(), randVal(),
                          int'($urandom_range(0, N / 2 - 1)));
            if ($urandom_range(0, 3) == 0)
                tick(1);
        end
        randReady = 1'b0;
        tick(1);
        out_ready = 1'b1;
        drainQueue();

        // Positive full-scale plus one, then reset with beats in flight.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        applyStimulus(32'sh7fff_ffff, 0, 1, 0, 0);
        repeat (3) @(negedge clk);
`ifdef BFU_SAT_EN
        checkOutput("t6_x0_re", x0_re, 64'sh7fff_ffff);
        checkOutput("t6_ovf", ovf, 1);
`else
        checkOutput("t6_x0_re", x0_re, -64'sh8000_0000);
        checkOutput("t6_ovf", ovf, 0);
`endif
        tick(1);
        applyStimulus(5, 6, 7, 8, 1);
        applyStimulus(9, 10, 11, 12, 3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_out_valid", out_valid, 0);
        checkOutput("rst_mid_ovf", ovf, 0);
        checkOutput("rst_mid_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("no_stale_beat", out_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
